// File: rtl/spi_bus_arbiter_if.sv
// Client/pin bundle for spi_bus_arbiter: request side plus the serial slave pins.
interface spi_bus_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [8*NREQ-1:0] addr;
    logic [8*NREQ-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [2:0]        done_id;
    logic [7:0]        rdata;
    logic              busy;
    logic              cs_n;
    logic              sdo;
    logic              sdi;

    modport master (
        input  req, we, addr, wdata, sdi,
        output gnt, done, done_id, rdata, busy, cs_n, sdo
    );

    modport slave (
        output req, we, addr, wdata, sdi,
        input  gnt, done, done_id, rdata, busy, cs_n, sdo
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one serial link to the SPI memory slave among NREQ requesters.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module spi_bus_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.master bus
);
    localparam int unsigned IDW = 3;
    localparam int unsigned CW  = 5;
    localparam int unsigned GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, WFRAME, RFRAME, GAP} state_t;

    state_t         state;
    logic [CW-1:0]  k;
    logic [CW-1:0]  kn;
    logic [GW-1:0]  gap_cnt;
    logic           we_q;
    logic [7:0]     addr_q;
    logic [7:0]     wdata_q;
    logic [6:0]     shreg;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] winner;
    logic           found;
    logic           sdo_next;

`ifdef SPI_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // Round-robin search starting at ptr
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && bus.req[(int'(ptr) + i) % int'(NREQ)]) begin
                found  = 1'b1;
                winner = IDW'((int'(ptr) + i) % int'(NREQ));
            end
        end
    end
`else
    // Fixed priority: lowest set index wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
    end
`endif

    assign kn = k + 5'd1;

    // Serial bit for frame cycle kn: 2-bit opcode, address LSB-first, then write byte or idle zeros
    always_comb begin
        sdo_next = 1'b0;
        if (kn < 5'd2)
            sdo_next = we_q;
        else if (kn < 5'd10)
            sdo_next = addr_q[3'(kn - 5'd2)];
        else if (we_q && kn < 5'd18)
            sdo_next = wdata_q[3'(kn - 5'd10)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            gap_cnt     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shreg       <= '0;
            id_q        <= '0;
            bus.gnt     <= '0;
            bus.done    <= 1'b0;
            bus.done_id <= '0;
            bus.rdata   <= '0;
            bus.busy    <= 1'b0;
            bus.cs_n    <= 1'b1;
            bus.sdo     <= 1'b0;
`ifdef SPI_ARB_RR_EN
            ptr         <= '0;
`endif
        end else begin
            bus.gnt  <= '0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.gnt  <= NREQ'(1) << winner;
                        we_q     <= bus.we[winner];
                        addr_q   <= bus.addr[int'(winner)*8 +: 8];
                        wdata_q  <= bus.wdata[int'(winner)*8 +: 8];
                        id_q     <= winner;
                        k        <= '0;
                        bus.cs_n <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.sdo  <= bus.we[winner];
                        state    <= bus.we[winner] ? WFRAME : RFRAME;
`ifdef SPI_ARB_RR_EN
                        ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                WFRAME: begin
                    k       <= kn;
                    bus.sdo <= sdo_next;
                    if (k == 5'd17) begin
                        bus.cs_n    <= 1'b1;
                        bus.sdo     <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.done_id <= id_q;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end
                end
                RFRAME: begin
                    k       <= kn;
                    bus.sdo <= sdo_next;
                    if (k >= 5'd12 && k < 5'd19)
                        shreg[3'(k - 5'd12)] <= bus.sdi;
                    // Bit 7 arrives on the closing edge and goes straight into rdata
                    if (k == 5'd19) begin
                        bus.cs_n    <= 1'b1;
                        bus.sdo     <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.done_id <= id_q;
                        bus.rdata   <= {bus.sdi, shreg};
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: vector table + scoreboard on a 2-requester
// instance, hand sequences on a 4-requester GAP_CYC=1 instance.
module tb_spi_bus_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.NREQ(2)) bus_a ();
    spi_bus_arbiter_if #(.NREQ(4)) bus_b ();

    spi_bus_arbiter #(.NREQ(2), .GAP_CYC(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    spi_bus_arbiter #(.NREQ(4), .GAP_CYC(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    typedef struct {
        logic       we;
        int         id;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] sbyte;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    int   gnt_q[$];
    logic abort_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
        if (k < 2) return v.we;
        if (k < 10) return v.addr[k-2];
        if (v.we && k < 18) return v.wdata[k-10];
        return 1'b0;
    endfunction

    // Frame monitor and serial slave model for instance A
    initial begin : mon_a
        int         k_a;
        int         hi_a;
        int         n;
        logic       in_a;
        logic       seen_a;
        logic [7:0] model_rdata;
        logic [19:0] bits_a;
        logic [19:0] e;
        vec_t       cur_a;
        k_a = 0; hi_a = 0; in_a = 0; seen_a = 0; model_rdata = 8'h00;
        bits_a = '0; cur_a = '{1'b0, 0, 8'h00, 8'h00, 8'h00};
        bus_a.sdi = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.gnt != '0) begin
                chk("gnt_at_frame_start", 32'(bus_a.cs_n == 1'b0 && !in_a), 32'd1);
                if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(bus_a.gnt), 32'd0);
                else chk("gnt_onehot", 32'(bus_a.gnt), 32'd1 << gnt_q.pop_front());
            end
            if (bus_a.done && !(bus_a.cs_n && in_a)) chk("done_spurious", 32'd1, 32'd0);
            if (!bus_a.cs_n) begin
                if (!in_a) begin
                    in_a = 1'b1; k_a = 0; bits_a = '0;
                    if (seen_a) chk("gap_high_cycles", 32'(hi_a >= 3), 32'd1);
                    if (!abort_exp) begin
                        if (exp_q.size() > 0) cur_a = exp_q.pop_front();
                        else chk("frame_unexpected", 32'd1, 32'd0);
                    end
                end
                if (k_a < 20) bits_a[k_a] = bus_a.sdo;
                bus_a.sdi = (k_a >= 12 && k_a <= 19) ? cur_a.sbyte[k_a-12] : 1'b0;
                k_a++;
                hi_a = 0;
            end else begin
                hi_a++;
                if (in_a) begin
                    in_a = 1'b0; seen_a = 1'b1; bus_a.sdi = 1'b0;
                    if (abort_exp) begin
                        chk("abort_low_cycles", 32'(k_a), 32'd8);
                        chk("abort_no_done", 32'(bus_a.done), 32'd0);
                        model_rdata = 8'h00;
                    end else begin
                        n = cur_a.we ? 18 : 20;
                        if (!cur_a.we) model_rdata = cur_a.sbyte;
                        e = '0;
                        for (int j = 0; j < n; j++) e[j] = exp_bit(cur_a, j);
                        chk("frame_low_cycles", 32'(k_a), 32'(n));
                        chk("done", 32'(bus_a.done), 32'd1);
                        chk("done_id", 32'(bus_a.done_id), 32'(cur_a.id));
                        chk("sdo_after_frame", 32'(bus_a.sdo), 32'd0);
                        chk("rdata", 32'(bus_a.rdata), 32'(model_rdata));
                        chk("sdo_bits", 32'(bits_a), 32'(e));
                        chk("busy_at_done", 32'(bus_a.busy), 32'd1);
                    end
                end
            end
        end
    end

    // which: 0 = gnt, 1 = done, other = busy low; cyc = negedges waited
    task automatic wait_ev(input bit on_b, input int which, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 60) begin
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = on_b ? (bus_b.gnt != '0) : (bus_a.gnt != '0);
                1:       hit = on_b ? bus_b.done : bus_a.done;
                default: hit = on_b ? !bus_b.busy : !bus_a.busy;
            endcase
        end
        if (!hit) chk("timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        @(negedge clk);
        bus_a.we[v.id]             = v.we;
        bus_a.addr[v.id*8 +: 8]    = v.addr;
        bus_a.wdata[v.id*8 +: 8]   = v.wdata;
        exp_q.push_back(v);
        gnt_q.push_back(v.id);
        bus_a.req[v.id]            = 1'b1;
        wait_ev(1'b0, 0, c);
        bus_a.req = '0;
        wait_ev(1'b0, 2, c);
    endtask

    initial begin : stim
        vec_t vecs[6];
        vec_t v;
        int   c;
        int   hi;
        int   blo;
        int   nf;
        vecs[0] = '{1'b1, 0, 8'h3C, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1, 8'h81, 8'h00, 8'h5E};
        vecs[2] = '{1'b1, 1, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b0, 0, 8'hFF, 8'h00, 8'h81};
        vecs[4] = '{1'b1, 0, 8'h55, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 1, 8'h01, 8'h00, 8'hC3};

        bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.sdi = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset values, then idle with no requests must stay static
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_cs_n", 32'(bus_a.cs_n), 32'd1);
            chk("idle_sdo", 32'(bus_a.sdo), 32'd0);
            chk("idle_gnt", 32'(bus_a.gnt), 32'd0);
            chk("idle_done", 32'(bus_a.done), 32'd0);
            chk("idle_done_id", 32'(bus_a.done_id), 32'd0);
            chk("idle_rdata", 32'(bus_a.rdata), 32'd0);
            chk("idle_busy", 32'(bus_a.busy), 32'd0);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset at k=7 of a write: frame abandoned, outputs back to reset values
        abort_exp = 1'b1;
        @(negedge clk);
        bus_a.we[0] = 1'b1; bus_a.addr[7:0] = 8'h12; bus_a.wdata[7:0] = 8'h34;
        gnt_q.push_back(0);
        bus_a.req[0] = 1'b1;
        wait_ev(1'b0, 0, c);
        bus_a.req = '0;
        repeat (7) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("rst_cs_n", 32'(bus_a.cs_n), 32'd1);
        chk("rst_sdo", 32'(bus_a.sdo), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        chk("rst_done_id", 32'(bus_a.done_id), 32'd0);
        chk("rst_rdata", 32'(bus_a.rdata), 32'd0);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        @(negedge clk);
        abort_exp = 1'b0;
        v = '{1'b1, 1, 8'hC0, 8'h3C, 8'h00};
        run_vec(v);

        // Both requesters held: arbitration order
        @(negedge clk);
        bus_a.we = 2'b11;
        bus_a.addr = {8'h20, 8'h10};
        bus_a.wdata = {8'h02, 8'h01};
`ifdef SPI_ARB_RR_EN
        nf = 4;
        for (int i = 0; i < nf; i++) begin
            exp_q.push_back('{1'b1, i % 2, (i % 2) ? 8'h20 : 8'h10, (i % 2) ? 8'h02 : 8'h01, 8'h00});
            gnt_q.push_back(i % 2);
        end
`else
        nf = 3;
        for (int i = 0; i < nf; i++) begin
            exp_q.push_back('{1'b1, 0, 8'h10, 8'h01, 8'h00});
            gnt_q.push_back(0);
        end
`endif
        bus_a.req = 2'b11;
        for (int i = 0; i < nf; i++) wait_ev(1'b0, 0, c);
        bus_a.req = '0;
        wait_ev(1'b0, 2, c);
        chk("scoreboard_frames_left", 32'(exp_q.size()), 32'd0);
        chk("scoreboard_gnts_left", 32'(gnt_q.size()), 32'd0);

        // Instance B: requester 3 read of 0xFF, slave returns all ones
        @(negedge clk);
        bus_b.we = 4'b0000; bus_b.addr[31:24] = 8'hFF;
        bus_b.req = 4'b1000;
        wait_ev(1'b1, 0, c);
        chk("b_gnt", 32'(bus_b.gnt), 32'h8);
        chk("b_gnt_latency", 32'(c), 32'd1);
        bus_b.req = '0;
        wait_ev(1'b1, 1, c);
        chk("b_read_len", 32'(c), 32'd20);
        chk("b_done_id", 32'(bus_b.done_id), 32'd3);
        chk("b_rdata", 32'(bus_b.rdata), 32'hFF);
        wait_ev(1'b1, 2, c);

        // Instance B: back-to-back writes with GAP_CYC=1
        @(negedge clk);
        bus_b.we = 4'b0001; bus_b.addr[7:0] = 8'h5A; bus_b.wdata[7:0] = 8'hC3;
        bus_b.req = 4'b0001;
        wait_ev(1'b1, 0, c);
        wait_ev(1'b1, 1, c);
        chk("b_write_len", 32'(c), 32'd18);
        hi = 0; blo = 0; c = 0;
        while (bus_b.cs_n && c < 20) begin
            hi++;
            if (!bus_b.busy) blo++;
            @(negedge clk);
            c++;
        end
        chk("b_gap_high", 32'(hi), 32'd2);
        chk("b_busy_low", 32'(blo), 32'd1);
        chk("b_second_gnt", 32'(bus_b.gnt), 32'h1);
        bus_b.req = '0;
        wait_ev(1'b1, 1, c);
        chk("b_second_done_id", 32'(bus_b.done_id), 32'd0);
        wait_ev(1'b1, 2, c);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
